// File: rtl/burst_arb_pkg.sv
// Shared types and helpers for the burst round-robin arbiter family.
// The state enum, the round-robin pick function and the counter-width helper live here.
package burst_arb_pkg;

    localparam int unsigned MAX_SRC   = 16;
    localparam int unsigned SRC_IDX_W = $clog2(MAX_SRC);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_e;

    // Width of a counter that must hold 0..max_beats inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_beats);
        return $clog2(max_beats + 1);
    endfunction

    // One-hot pick of the first requester found at last+1, last+2, ... (mod n).
    function automatic logic [MAX_SRC-1:0] rr_pick(
        input logic [MAX_SRC-1:0]   req,
        input logic [SRC_IDX_W-1:0] last,
        input int unsigned          n
    );
        logic [MAX_SRC-1:0] pick;
        logic               found;
        int unsigned        idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_SRC; i++) begin
            idx = (32'(last) + i) % n;
            if (i <= n && !found && req[idx[SRC_IDX_W-1:0]]) begin
                pick[idx[SRC_IDX_W-1:0]] = 1'b1;
                found                    = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/burst_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', as a one-hot grant.
// Reusable by any arbiter that keeps its own last-served index.
module burst_rr_pick
    import burst_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]   req,
    input  logic [SRC_IDX_W-1:0] last,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 any
);

    always_comb begin
        grant = NUM_SRC'(rr_pick(MAX_SRC'(req), last, NUM_SRC));
        any   = |req;
    end

endmodule

// File: rtl/burst_rr_arbiter.sv
// Round-robin burst arbiter feeding one sink through a registered single-beat output stage.
// Define BURST_ARB_MAX_BEATS_EN to cap each grant at MAX_BEATS accepted beats.
module burst_rr_arbiter
    import burst_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_BEATS = 64
) (
    input  logic                     i_clk,
    input  logic                     i_srst,
    input  logic [NUM_SRC*WIDTH-1:0] i_bdata,
    input  logic [NUM_SRC-1:0]       i_bvalid,
    output logic [NUM_SRC-1:0]       o_bready,
    output logic [WIDTH-1:0]         o_bdata,
    output logic                     o_bvalid,
    input  logic                     i_bready,
    output logic [NUM_SRC-1:0]       o_grant,
    output logic                     o_busy
);

    localparam int unsigned IdxW = $clog2(NUM_SRC);

    if (NUM_SRC < 2 || NUM_SRC > MAX_SRC || MAX_BEATS < 1) begin : g_param_check
        $error("burst_rr_arbiter: NUM_SRC must be 2..16 and MAX_BEATS at least 1");
    end

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [IdxW-1:0]    last_q, last_d;
    logic [WIDTH-1:0]   bdata_q, bdata_d;
    logic               bvalid_q, bvalid_d;

    logic [NUM_SRC-1:0] pick;
    logic               pick_any;
    logic [IdxW-1:0]    pick_idx;
    logic               src_valid;
    logic [WIDTH-1:0]   src_data;
    logic               out_free;
    logic               xfer;
    logic               at_limit;

    burst_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req   (i_bvalid),
        .last  (SRC_IDX_W'(last_q)),
        .grant (pick),
        .any   (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (pick[k]) pick_idx = IdxW'(k);
        end
    end

    // last_q doubles as the granted index while in ST_GRANT.
    always_comb begin
        src_valid = i_bvalid[last_q];
        src_data  = i_bdata[last_q*WIDTH +: WIDTH];
        out_free  = ~bvalid_q | i_bready;
        xfer      = (state_q == ST_GRANT) && src_valid && out_free;
        o_bready  = '0;
        if (state_q == ST_GRANT) o_bready = grant_q & {NUM_SRC{out_free}};
    end

`ifdef BURST_ARB_MAX_BEATS_EN
    localparam int unsigned CntW = cnt_width(MAX_BEATS);
    logic [CntW-1:0] cnt_q, cnt_d;

    assign at_limit = xfer && (cnt_q == CntW'(MAX_BEATS - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) cnt_d = '0;
        else if (xfer)          cnt_d = cnt_q + CntW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign at_limit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        bdata_d  = bdata_q;
        bvalid_d = bvalid_q;
        // Output register drains independently of arbitration state.
        if (xfer) begin
            bdata_d  = src_data;
            bvalid_d = 1'b1;
        end else if (i_bready) begin
            bvalid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    grant_d = pick;
                    last_d  = pick_idx;
                end
            end
            ST_GRANT: begin
                if (!src_valid || at_limit) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            last_q   <= IdxW'(NUM_SRC - 1);
            bdata_q  <= '0;
            bvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            bdata_q  <= bdata_d;
            bvalid_q <= bvalid_d;
        end
    end

    assign o_bdata  = bdata_q;
    assign o_bvalid = bvalid_q;
    assign o_grant  = grant_q;
    assign o_busy   = (state_q == ST_GRANT);

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Bench for burst_rr_arbiter: vector tables, reset corner case, and a transaction-level model
// (source queues, round-robin rule, per-grant beat accounting, ordered output scoreboard).
module tb_burst_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned MB = 4;
`ifdef BURST_ARB_MAX_BEATS_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           i_srst;
    logic [N*W-1:0] i_bdata;
    logic [N-1:0]   i_bvalid;
    logic [N-1:0]   o_bready;
    logic [W-1:0]   o_bdata;
    logic           o_bvalid;
    logic           i_bready;
    logic [N-1:0]   o_grant;
    logic           o_busy;

    burst_rr_arbiter #(.NUM_SRC(N), .WIDTH(W), .MAX_BEATS(MB)) dut (
        .i_clk    (clk),
        .i_srst   (i_srst),
        .i_bdata  (i_bdata),
        .i_bvalid (i_bvalid),
        .o_bready (o_bready),
        .o_bdata  (o_bdata),
        .o_bvalid (o_bvalid),
        .i_bready (i_bready),
        .o_grant  (o_grant),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [N-1:0] bv;
        logic [W-1:0] d;
        logic         rdy;
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_gnt;
        logic         e_v;
        logic [W-1:0] e_d;
    } vec_t;

    function automatic vec_t mkv(input logic [N-1:0] bv, input logic [W-1:0] d, input logic rdy,
                                 input logic [N-1:0] e_rdy, input logic [N-1:0] e_gnt,
                                 input logic e_v, input logic [W-1:0] e_d);
        vec_t v;
        v.bv = bv; v.d = d; v.rdy = rdy; v.e_rdy = e_rdy; v.e_gnt = e_gnt; v.e_v = e_v; v.e_d = e_d;
        return v;
    endfunction

    vec_t vt[$];

    // ---------------- transaction-level model state ----------------
    int           left[N];
    int           gap[N];
    int           seq[N];
    int           bursts[N][$];
    logic [W-1:0] exp_q[$];
    int           m_last;
    int           cur_beats;
    int           cur_exp;
    int           max_gap_extra;
    bit           rand_ready;
    int           log_src[$];
    int           log_beats[$];
    int           rise_cyc[$];

    function automatic logic [W-1:0] mk_data(input int k, input int s);
        return W'((k << 12) | (s & 'hfff));
    endfunction

    function automatic int rr_ref(input logic [N-1:0] req, input int last);
        for (int i = 1; i <= int'(N); i++) begin
            int idx = (last + i) % int'(N);
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        i_srst = 1'b1; i_bvalid = '0; i_bdata = '0; i_bready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        i_srst = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            left[k] = 0; gap[k] = 0; seq[k] = 0;
            bursts[k].delete();
        end
        exp_q.delete(); log_src.delete(); log_beats.delete(); rise_cyc.delete();
        m_last = N - 1; cur_beats = 0; cur_exp = 0;
    endtask

    task automatic model_cycle();
        logic [N-1:0]   bv, acc, req, g_before, exp_g;
        logic [N*W-1:0] bd;
        logic           down_acc;
        logic [W-1:0]   d_before, e_data;
        int             a, e;
        bit             hold;
        @(negedge clk);
        bv = '0; bd = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (left[k] == 0) begin
                if (gap[k] > 0) gap[k]--;
                else if (bursts[k].size() > 0) left[k] = bursts[k].pop_front();
            end
            bv[k] = (left[k] > 0);
            bd[k*W +: W] = mk_data(k, seq[k]);
        end
        i_bvalid = bv; i_bdata = bd;
        i_bready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        acc = o_bready & i_bvalid; down_acc = o_bvalid & i_bready; d_before = o_bdata;
        req = i_bvalid; g_before = o_grant;
        @(posedge clk);
        #1;
        if (down_acc) begin
            e_data = 'x;
            if (exp_q.size() > 0) e_data = exp_q.pop_front();
            chk("out_beat_order", d_before, e_data);
        end
        if (acc != 0) begin
            chk("acc_only_granted", acc & ~g_before, 0);
            a = 0;
            for (int k = int'(N) - 1; k >= 0; k--) if (acc[k]) a = k;
            chk("src_to_out_latency", {o_bvalid, o_bdata}, {1'b1, mk_data(a, seq[a])});
            exp_q.push_back(mk_data(a, seq[a]));
            seq[a]++; left[a]--; cur_beats++;
            if (left[a] == 0) gap[a] = 1 + $urandom_range(0, max_gap_extra);
        end
        if (g_before == 0) begin
            exp_g = '0;
            if (req != 0) begin
                e = rr_ref(req, m_last);
                exp_g = N'(1 << e);
                m_last = e; cur_beats = 0;
                cur_exp = (LIMIT_EN && left[e] > int'(MB)) ? int'(MB) : left[e];
                log_src.push_back(e); rise_cyc.push_back(cyc);
            end
            chk("rr_grant", o_grant, exp_g);
        end else begin
            hold  = ((req & g_before) != 0) && !(LIMIT_EN && cur_beats == int'(MB));
            exp_g = hold ? g_before : '0;
            chk("grant_hold_release", o_grant, exp_g);
            if (!hold) begin
                chk("beats_per_grant", cur_beats, cur_exp);
                log_beats.push_back(cur_beats);
            end
        end
        chk("busy", o_busy, exp_g != 0);
    endtask

    task automatic run_model(input int budget, input string name);
        int  n = 0;
        bit  idle;
        while (n < budget) begin
            model_cycle();
            n++;
            idle = 1'b1;
            for (int k = 0; k < int'(N); k++) if (left[k] != 0 || bursts[k].size() != 0) idle = 1'b0;
            if (idle && exp_q.size() == 0 && o_grant == 0 && !o_bvalid) break;
        end
        chk({name, "_drained"}, n < budget, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rot[5];
        int exp_src[$];
        int exp_bts[$];
        i_srst = 1'b1; i_bvalid = '0; i_bdata = '0; i_bready = 1'b0;
        max_gap_extra = 0; rand_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", o_grant, 0);
        chk("rst_bvalid", o_bvalid, 0);
        chk("rst_bdata", o_bdata, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_bready", o_bready, 0);
        @(negedge clk);
        i_srst = 1'b0;

        // Single source burst, then a mid-burst downstream stall
        vt.push_back(mkv(4'b0010, 16'hA001, 1, 4'b0000, 4'b0010, 0, 16'h0000));
        vt.push_back(mkv(4'b0010, 16'hA001, 1, 4'b0010, 4'b0010, 1, 16'hA001));
        vt.push_back(mkv(4'b0010, 16'hA002, 1, 4'b0010, 4'b0010, 1, 16'hA002));
        vt.push_back(mkv(4'b0010, 16'hA003, 1, 4'b0010, 4'b0010, 1, 16'hA003));
        vt.push_back(mkv(4'b0000, 16'hA003, 1, 4'b0010, 4'b0000, 0, 16'hA003));
        vt.push_back(mkv(4'b0000, 16'hA003, 1, 4'b0000, 4'b0000, 0, 16'hA003));
        vt.push_back(mkv(4'b0100, 16'hB001, 1, 4'b0000, 4'b0100, 0, 16'hA003));
        vt.push_back(mkv(4'b0100, 16'hB001, 1, 4'b0100, 4'b0100, 1, 16'hB001));
        for (int i = 0; i < 5; i++)
            vt.push_back(mkv(4'b0100, 16'hB002, 0, 4'b0000, 4'b0100, 1, 16'hB001));
        vt.push_back(mkv(4'b0100, 16'hB002, 1, 4'b0100, 4'b0100, 1, 16'hB002));
        vt.push_back(mkv(4'b0100, 16'hB003, 1, 4'b0100, 4'b0100, 1, 16'hB003));
        vt.push_back(mkv(4'b0000, 16'hB003, 1, 4'b0100, 4'b0000, 0, 16'hB003));
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            i_bvalid = vt[i].bv; i_bdata = {N{vt[i].d}}; i_bready = vt[i].rdy;
            #1;
            chk($sformatf("vec%0d_bready", i), o_bready, vt[i].e_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_grant", i), o_grant, vt[i].e_gnt);
            chk($sformatf("vec%0d_bvalid", i), o_bvalid, vt[i].e_v);
            chk($sformatf("vec%0d_bdata", i), o_bdata, vt[i].e_d);
            chk($sformatf("vec%0d_busy", i), o_busy, vt[i].e_gnt != 0);
        end

        // Synchronous reset in mid-burst with a beat in flight
        do_reset();
        @(negedge clk);
        i_bvalid = 4'b0100; i_bdata = {N{16'hC001}}; i_bready = 1'b1;
        @(posedge clk); #1;
        chk("srst_pre_grant", o_grant, 4'b0100);
        @(posedge clk); #1;
        chk("srst_pre_beat", {o_bvalid, o_bdata}, {1'b1, 16'hC001});
        @(negedge clk);
        i_srst = 1'b1;
        @(posedge clk); #1;
        chk("srst_grant", o_grant, 0);
        chk("srst_bvalid", o_bvalid, 0);
        chk("srst_bdata", o_bdata, 0);
        chk("srst_busy", o_busy, 0);
        chk("srst_bready", o_bready, 0);
        @(negedge clk);
        i_srst = 1'b0; i_bvalid = 4'b1001;
        i_bdata = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        @(posedge clk); #1;
        chk("srst_next_src0", o_grant, 4'b0001);
        chk("srst_next_nobeat", o_bvalid, 0);
        @(posedge clk); #1;
        chk("srst_next_data", {o_bvalid, o_bdata}, {1'b1, 16'hD000});

        // All sources with back-to-back 2-beat bursts: strict rotation, 4-cycle grant period
        do_reset();
        for (int k = 0; k < int'(N); k++) begin
            bursts[k].push_back(2);
            bursts[k].push_back(2);
        end
        max_gap_extra = 0; rand_ready = 1'b0;
        run_model(200, "rot");
        exp_rot = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++)
            chk($sformatf("rot_order%0d", i), (log_src.size() > i) ? log_src[i] : -1, exp_rot[i]);
        for (int i = 1; i < 5; i++)
            chk($sformatf("rot_period%0d", i), (rise_cyc.size() > i) ? rise_cyc[i] - rise_cyc[i-1] : -1, 4);

        // Long burst from source 0 competing with a short one from source 3
        do_reset();
        bursts[0].push_back(10);
        bursts[3].push_back(2);
        run_model(300, "mb");
        if (LIMIT_EN) begin
            exp_src = '{0, 3, 0, 0}; exp_bts = '{4, 2, 4, 2};
        end else begin
            exp_src = '{0, 3}; exp_bts = '{10, 2};
        end
        chk("mb_grant_count", log_src.size(), exp_src.size());
        for (int i = 0; i < exp_src.size(); i++) begin
            chk($sformatf("mb_src%0d", i), (log_src.size() > i) ? log_src[i] : -1, exp_src[i]);
            chk($sformatf("mb_beats%0d", i), (log_beats.size() > i) ? log_beats[i] : -1, exp_bts[i]);
        end

        // Random bursts, gaps and downstream backpressure
        do_reset();
        for (int k = 0; k < int'(N); k++)
            for (int b = 0; b < 6; b++) bursts[k].push_back(int'($urandom_range(1, 7)));
        max_gap_extra = 2; rand_ready = 1'b1;
        run_model(3000, "rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_rr_arbiter.md
Name: burst_rr_arbiter

Overview:
- Shares one downstream burst sink among NUM_SRC upstream burst sources (bdata/bvalid/bready handshake).
- Round-robin grant, held for a whole burst: a maximal run of consecutive bvalid-high cycles from the granted source.
- Registered single-beat output stage. Sits between multiple DSP/packet producers and a shared burst consumer (e.g. a FIFO or MAC feeder).

Parameters:
- NUM_SRC, 4, number of upstream requesters (2..16).
- WIDTH, 16, bdata width in bits.
- MAX_BEATS, 64, beat limit per grant; only used when BURST_ARB_MAX_BEATS_EN is defined.

Ports:
- i_clk  in  1  sole clock; all logic rising-edge.
- i_srst  in  1  synchronous active-high reset.
- i_bdata  in  NUM_SRC*WIDTH  source data; source k occupies bits [k*WIDTH +: WIDTH].
- i_bvalid  in  NUM_SRC  per-source valid.
- o_bready  out  NUM_SRC  per-source ready.
- o_bdata  out  WIDTH  downstream data (registered).
- o_bvalid  out  1  downstream valid (registered).
- i_bready  in  1  downstream ready.
- o_grant  out  NUM_SRC  one-hot current grant; 0 when idle.
- o_busy  out  1  high while state is GRANT.

Behaviour:
- Clock and reset: one clock, i_clk; reset is synchronous and active-high, i_srst.
- Transfer rule: a beat transfers when valid and ready are both high on a rising edge. Sources keep bvalid and bdata stable until accepted. A deasserted bvalid from the granted source marks end of burst.
- Reset values:
  - o_bvalid=0, o_bdata=0, o_bready=0, o_grant=0, o_busy=0.
  - State=IDLE, beat counter=0.
  - Round-robin pointer last=NUM_SRC-1, so source 0 wins first.
- IDLE state:
  - o_bready all 0.
  - If any i_bvalid is high, pick the first requesting index searching last+1, last+2, ... (mod NUM_SRC).
  - Register the pick into o_grant, set last to it, go to GRANT.
  - Arbitration costs exactly 1 cycle; no beat is accepted in the IDLE cycle.
- GRANT state, granted source g:
  - o_bready[g] = ~o_bvalid | i_bready. All other o_bready = 0.
  - On a source transfer: o_bdata <= i_bdata[g], o_bvalid <= 1.
  - Otherwise, if i_bready: o_bvalid <= 0.
  - Release to IDLE (o_grant <= 0 next cycle) when i_bvalid[g]==0 in any GRANT cycle, whether or not ready is high.
- Output stage behaviour:
  - The output register keeps draining after release and in IDLE.
  - A new grant may be issued while o_bvalid is still 1.
  - Source-to-o_bvalid latency: 1 cycle.
  - Throughput: 1 beat/cycle while i_bready is high.
  - Burst-to-burst gap: at least 2 cycles (release cycle plus arbitration cycle).
- Boundary conditions:
  - Simultaneous requests from all sources are served in strict rotation.
  - A single continuous requester is re-granted after each release.
  - Downstream stall (i_bready=0 with o_bvalid=1) holds o_bdata and drops o_bready[g]; the grant is held.
  - i_srst in mid-burst returns everything to reset values on the next edge. An in-flight output beat is discarded.
- No combinational path exists from i_bvalid to o_bvalid. o_bready depends combinationally on i_bready and state only.

Optional Feature:
- BURST_ARB_MAX_BEATS_EN.
- Defined:
  - A counter increments per accepted source beat in GRANT.
  - When the counter reaches MAX_BEATS, release on that cycle and go to IDLE. The source's remaining beats wait for rotation.
  - The counter clears on entry to GRANT.
- Undefined:
  - No counter exists. A grant lasts until the source drops bvalid, so a source that never gaps can starve others; this is documented as acceptable.

Decomposition:
- Shared package burst_arb_pkg:
  - state enum {ST_IDLE, ST_GRANT}.
  - function rr_pick(req, last) returning a one-hot value.
  - localparam for the counter width, $clog2(MAX_BEATS+1).
- One natural sub-module, burst_rr_pick: combinational round-robin picker (req, last -> one-hot grant, any), reusable by other arbiters.

Test Plan:
- Reset, then only source 1 sends 3 beats 0xA001..0xA003 with i_bready=1 -> o_grant=0b0010 one cycle after bvalid. o_bdata shows A001, A002, A003 on consecutive cycles. o_grant=0 after the source drops bvalid.
- NUM_SRC=4, all sources each send a 2-beat burst continuously -> grant order 0,1,2,3,0. No beat reorders within a burst. Gap of 2 cycles between bursts.
- Downstream stall: i_bready=0 for 5 cycles in mid-burst of source 2 -> o_bvalid stays 1, o_bdata held, o_bready[2]=0. Remaining beats arrive intact, with no drop or duplicate.
- i_srst pulsed for 1 cycle during a GRANT with o_bvalid=1 -> next cycle all outputs 0, state IDLE. The next request goes to source 0.
- With BURST_ARB_MAX_BEATS_EN, MAX_BEATS=4: source 0 sends 10 beats and source 3 sends 2 -> grant sequence src0 (4 beats), src3 (2), src0 (4), src0 (2).
- Without the macro, same stimulus -> src0 sends all 10 beats, then src3 sends 2.
